instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Fetch sequencer for the byte-addressed, combinational-read instruction memory. Owns the program counter, drives the memory address, captures each returned 32-bit little-endian word with its PC into a small prefetch queue, and hands entries to decode over a valid/ready handshake. Accepts branch/jump redirects that flush the queue. Stops cleanly at the end of the memory image or on a misaligned redirect.

## Interface
- RESET_PC, 0: PC loaded at reset; must be a multiple of 4.
- MEM_BYTES, 128: instruction memory size in bytes; last fetchable address is MEM_BYTES-4.
- DEPTH, 2: prefetch queue entries; power of two, ≥2.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
- imem_addr  out  32  byte address to instruction memory; always equals PC.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  load redirect_pc this cycle and flush.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- halted  out  1  controller is in HALT.
- fault  out  1  sticky; last HALT entry was a misaligned redirect.

## Operation
- States: IDLE, FETCH, HALT. Reset → IDLE.
- IDLE: no pushes. start → FETCH. redirect_valid in IDLE updates PC (alignment rules below) but stays in IDLE.
- FETCH, per cycle: push {PC, imem_data} if queue has room (count<DEPTH, or count==DEPTH and a pop happens the same cycle); on push PC ← PC+4. No push → PC holds.
- End of image: in FETCH, if PC > MEM_BYTES-4, no push; → HALT, halted=1, fault unchanged. Queue keeps draining.
- Redirect (any state): highest priority. Queue flushed (count=0, out_valid=0 next cycle); any same-cycle push is discarded; a same-cycle pop is treated as taken. If redirect_pc[1:0]==0: PC ← redirect_pc, fault ← 0; HALT→FETCH, FETCH stays FETCH, IDLE stays IDLE. If misaligned: PC unchanged, → HALT, fault ← 1.
- start while in FETCH or HALT: ignored.
- Pop: out_valid && out_ready removes head. Head order = fetch order.
- PC arithmetic: 32-bit, wraps modulo 2^32 (unreachable within bounds check).

## Timing
- Reset values: PC=RESET_PC (imem_addr=RESET_PC), out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, queue empty, state IDLE.
- rst_n low at any time, including mid-fetch: immediate return to reset values; queue contents lost.
- Fetch latency: word at PC sampled on the edge closing cycle t; appears at head in cycle t+1 if queue was empty.
- Steady state with out_ready=1: one instruction per cycle after the first.
- out_valid/out_instr/out_pc are registered; no combinational path from out_ready or redirect_valid to any output.
- Redirect at edge t: first instruction from target at head in cycle t+2.
- halted asserts the cycle after the failed bound check or misaligned redirect.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, count of pushes not discarded by redirect) and perf_stalls (32, FETCH cycles with no push due to full queue); both reset to 0, saturate at 2^32-1.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, start, out_ready=1, memory holds 0x00000013 at 0..0x7C → out_pc 0,4,8,… one per cycle from cycle 2 after start; out_instr=0x00000013.
- out_ready=0 for 6 cycles after start → exactly DEPTH=2 entries (pc 0, 4), imem_addr holds 8; release → pc 8 delivered third, none lost or duplicated.
- Redirect to 0x40 while queue holds pc 0x10, 0x14 → those never delivered; next out_pc=0x40 two cycles after redirect.
- Run to end with MEM_BYTES=128 → last out_pc=0x7C, halted=1, fault=0, no fetch at 0x80; then aligned redirect to 0x0 → fetching resumes, halted=0.
- Redirect to 0x22 → halted=1, fault=1, queue empty, PC unchanged; then redirect to 0x20 → fault=0, out_pc=0x20.
- rst_n pulsed low mid-stream with queue full → all outputs at reset values asynchronously; state IDLE until next start.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Fetch sequencer for a byte-addressed instruction memory that returns data
//   combinationally. It owns the PC and drives it as the memory address. Each
//   returned word is stored with its PC in a small prefetch queue, and the
//   queue head goes to decode over a valid/ready handshake.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           one-cycle pulse that moves the controller from IDLE to FETCH
//   imem_addr       byte address to instruction memory (always the PC)
//   imem_data       instruction word for imem_addr
//   redirect_valid  redirect_pc  branch/jump target; flushes the queue
//   out_valid       out_ready    decode handshake for the queue head
//   out_instr       out_pc       head instruction and its PC
//   halted          controller is in HALT
//   fault           sticky flag: the last HALT entry was a misaligned redirect
//
// Optional feature, macro FETCH_PERF_EN:
//   perf_fetched    count of pushes (saturating)
//   perf_stalls     FETCH cycles lost because the queue was full (saturating)
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 128,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW        = PW + 1;
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t                  state;
    logic [31:0]             pc;
    logic [DEPTH-1:0][31:0]  q_instr;
    logic [DEPTH-1:0][31:0]  q_pc;
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           count;

    logic pop;
    logic in_bounds;
    logic has_room;
    logic push;
    logic redir_misaligned;

    // A full queue still accepts a push when its head leaves on the same
    // edge. Both pointers address the same slot in that case, and the old
    // entry has already been consumed.
    assign pop              = (count != '0) && out_ready;
    assign in_bounds        = (pc <= LAST_ADDR);
    assign has_room         = (count < CW'(DEPTH)) || pop;
    assign push             = (state == FETCH) && !redirect_valid && in_bounds && has_room;
    assign redir_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            fault   <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_instr <= '0;
            q_pc    <= '0;
        end else if (redirect_valid) begin
            // A redirect overrides everything else: it drops any same-cycle
            // push and treats any same-cycle pop as taken, because the whole
            // queue is discarded.
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (redir_misaligned) begin
                state <= HALT;
                fault <= 1'b1;
            end else begin
                pc    <= redirect_pc;
                fault <= 1'b0;
                if (state == HALT)
                    state <= FETCH;
            end
        end else begin
            case (state)
                IDLE:    if (start) state <= FETCH;
                FETCH:   if (!in_bounds) state <= HALT;
                default: ;
            endcase
            if (push) begin
                q_instr[tail] <= imem_data;
                q_pc[tail]    <= pc;
                tail          <= tail + 1'b1;
                pc            <= pc + 32'd4;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // All outputs come from state registers only. There is no combinational
    // path from out_ready or redirect_valid to any output.
    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_instr = q_instr[head];
    assign out_pc    = q_pc[head];
    assign halted    = (state == HALT);

`ifdef FETCH_PERF_EN
    logic stall;
    // A stall is a FETCH cycle in which a push was possible except for the
    // full queue. Redirect and end-of-image cycles do not count as stalls.
    assign stall = (state == FETCH) && !redirect_valid && in_bounds && !has_room;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (push && (perf_fetched != 32'hFFFF_FFFF))
                perf_fetched <= perf_fetched + 32'd1;
            if (stall && (perf_stalls != 32'hFFFF_FFFF))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    // mode 0: every word is 0x00000013; mode 1: word = 0xA5000000 | address
    logic mem_mode;
    assign imem_data = mem_mode ? (32'hA500_0000 | imem_addr) : 32'h0000_0013;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.RESET_PC(32'h0), .MEM_BYTES(128), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b0; mem_mode = 1'b0;

        // ---- reset values
        do_reset();
        chk("rst_addr",   imem_addr,        32'h0);
        chk("rst_valid",  32'(out_valid),   32'h0);
        chk("rst_instr",  out_instr,        32'h0);
        chk("rst_pc",     out_pc,           32'h0);
        chk("rst_halted", 32'(halted),      32'h0);
        chk("rst_fault",  32'(fault),       32'h0);

        // ---- streaming, one per cycle from cycle 2 after start
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("s_valid_c1", 32'(out_valid), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("s_valid", 32'(out_valid), 32'h1);
            chk("s_pc",    out_pc,         32'(4 * i));
            chk("s_instr", out_instr,      32'h0000_0013);
            tick();
        end

        // ---- backpressure: queue holds exactly two entries
        do_reset();
        mem_mode = 1'b1; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_pc0",   out_pc,         32'h0);
        chk("bp_addr",  imem_addr,      32'h8);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_seq_pc",    out_pc,    32'(4 * i));
            chk("bp_seq_instr", out_instr, 32'hA500_0000 | 32'(4 * i));
            tick();
        end

        // ---- redirect in IDLE, then flush of queued 0x10/0x14
        do_reset();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        chk("idle_redir_addr",   imem_addr,       32'h10);
        chk("idle_redir_halted", 32'(halted),     32'h0);
        chk("idle_redir_valid",  32'(out_valid),  32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("fl_head",  out_pc,    32'h10);
        chk("fl_addr",  imem_addr, 32'h18);
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("fl_valid_t1", 32'(out_valid), 32'h0);
        chk("fl_addr_t1",  imem_addr,      32'h40);
        tick();
        chk("fl_valid_t2", 32'(out_valid), 32'h1);
        chk("fl_pc_t2",    out_pc,         32'h40);
        chk("fl_instr_t2", out_instr,      32'hA500_0040);

        // ---- run to end of image
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("end_pc", out_pc, 32'h40 + 32'(4 * k));
        end
        tick();
        chk("end_halted", 32'(halted),    32'h1);
        chk("end_fault",  32'(fault),     32'h0);
        chk("end_valid",  32'(out_valid), 32'h0);
        chk("end_addr",   imem_addr,      32'h80);
        tick();
        chk("end_valid2", 32'(out_valid), 32'h0);
        chk("end_addr2",  imem_addr,      32'h80);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_addr",   imem_addr,   32'h0);
        tick();
        chk("resume_valid", 32'(out_valid), 32'h1);
        chk("resume_pc",    out_pc,         32'h0);

        // ---- misaligned redirect, then aligned recovery
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        chk("mis_halted", 32'(halted),    32'h1);
        chk("mis_fault",  32'(fault),     32'h1);
        chk("mis_valid",  32'(out_valid), 32'h0);
        chk("mis_addr",   imem_addr,      32'h4);
        tick();
        chk("mis_valid2", 32'(out_valid), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        chk("rec_fault",  32'(fault),  32'h0);
        chk("rec_halted", 32'(halted), 32'h0);
        chk("rec_addr",   imem_addr,   32'h20);
        tick();
        chk("rec_valid", 32'(out_valid), 32'h1);
        chk("rec_pc",    out_pc,         32'h20);
        chk("rec_instr", out_instr,      32'hA500_0020);

        // ---- asynchronous reset clears a sticky fault
        redirect_valid = 1'b1; redirect_pc = 32'h23;
        tick();
        redirect_valid = 1'b0;
        chk("pre_rst_fault", 32'(fault), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fault",  32'(fault),  32'h0);
        chk("arst_halted", 32'(halted), 32'h0);
        tick();
        rst_n = 1'b1;

        // ---- asynchronous reset mid-stream with a full queue
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick();
        redirect_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("full_pc",   out_pc,    32'h30);
        chk("full_addr", imem_addr, 32'h38);
        #2 rst_n = 1'b0;
        #1;
        chk("arst2_valid", 32'(out_valid), 32'h0);
        chk("arst2_pc",    out_pc,         32'h0);
        chk("arst2_instr", out_instr,      32'h0);
        chk("arst2_addr",  imem_addr,      32'h0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_idle_valid", 32'(out_valid), 32'h0);
        chk("post_idle_addr",  imem_addr,      32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_valid", 32'(out_valid), 32'h1);
        chk("restart_pc",    out_pc,         32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
